// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,   // waiting for word-count low byte
        S_HDR1 = 3'd1,   // waiting for word-count high byte
        S_DATA = 3'd2,   // streaming instruction bytes
        S_DONE = 3'd3,   // load complete, core released
        S_ERR  = 3'd4    // oversize header or inter-byte timeout
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; one-cycle word_vld_o pulse per word.
// Latency: word_vld_o/word_dat_o registered, one cycle after the 4th byte is accepted.
// Backpressure: none; assembly and output registers are separate, so a byte can arrive every cycle.
// Ports: clk, rst (async active-low), clr_i (drop partial word),
//        byte_vld_i/byte_dat_i (accepted byte), word_vld_o/word_dat_o (completed word).
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       word_q, word_d;
    logic              vld_q, vld_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (clr_i) begin
            // Clearing the assembly register too guarantees no stale lanes after an abort.
            lane_d = '0;
            asm_d  = '0;
        end else if (byte_vld_i) begin
            asm_d[{lane_q, 3'b000} +: 8] = byte_dat_i;
            if (lane_q == LAST_LANE) begin
                // Final byte goes straight into the output word so the write happens next cycle.
                word_d = {byte_dat_i, asm_q[23:0]};
                vld_d  = 1'b1;
                lane_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
            asm_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word_vld_o = vld_q;
    assign word_dat_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a 16-bit LE word count then LE instruction words, writes them into imem,
// and holds the core in reset until every word is written. Latency: imem write one cycle after
// the 4th byte of a word; done/core_rst one cycle after the last write. Backpressure: rx_ready
// is high in S_HDR0/S_HDR1/S_DATA (one byte per cycle sustained), low in S_DONE/S_ERR.
// Ports: clk, rst (async active-low); rx_valid/rx_ready/rx_data byte stream; restart (re-arm);
//        imem_we/imem_addr/imem_wdata memory write; core_rst (active-low core reset);
//        busy/done/error status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          TO_W      = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    // One extra bit so a full-memory load can count to 2**ADDR_W without wrapping.
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [TO_W-1:0]   idle_q, idle_d;

    logic              accept;
    logic [15:0]       hdr_cnt;
    logic              last_word;
    logic              word_vld;
    logic [31:0]       word_dat;

    assign rx_ready  = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
    assign accept    = rx_valid && rx_ready;
    assign hdr_cnt   = {rx_data, cnt_q[7:0]};
    assign last_word = (17'(idx_q) + 17'd1) == {1'b0, cnt_q};

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q != S_DATA),
        .byte_vld_i (accept && (state_q == S_DATA)),
        .byte_dat_i (rx_data),
        .word_vld_o (word_vld),
        .word_dat_o (word_dat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        unique case (state_q)
            S_HDR0: begin
                idle_d = '0;
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    idle_d      = '0;
                    if (hdr_cnt == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, hdr_cnt} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            S_DATA: begin
                if (accept) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
                // A write cycle always follows an accept, so it can never coincide with a timeout.
                if (word_vld) begin
                    idx_d = idx_q + (ADDR_W + 1)'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE, S_ERR: begin
                idle_d = '0;
                if (restart) begin
                    state_d = S_HDR0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR0;
            cnt_q   <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
        end
    end

    // Status outputs decode the registered state, so core_rst rises on the first cycle
    // after the final write and drops on the cycle after a restart.
    assign imem_we    = word_vld && (state_q == S_DATA);
    assign imem_addr  = idx_q[ADDR_W-1:0];
    assign imem_wdata = word_dat;
    assign core_rst   = (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign busy       = (state_q == S_HDR1) || (state_q == S_DATA);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with a small memory and short timeout.
// Latency: n/a. Backpressure: bench waits on rx_ready with a bounded retry loop.
module tb_imem_loader;

    localparam int ADDR_W = 4;
    localparam int TO_CYC = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              restart = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        bit r;
        ok       = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) begin
            n_checks++;
            $display("FAIL byte_accept: got rx_ready=0 for 20 cycles expected 1");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        if (n > 0) #1;
    endtask

    // Reference: count 0 finishes at once, count above memory depth errors,
    // otherwise word i lands at address i and the core runs afterwards.
    task automatic run_load(input logic [15:0] cnt, input int gap_max);
        bit ok;
        logic [31:0] w;
        send_byte(cnt[7:0], ok);
        if (!ok) return;
        chk("busy_in_header", 32'(busy), 32'd1);
        idle($urandom_range(gap_max, 0));
        send_byte(cnt[15:8], ok);
        if (!ok) return;
        if (cnt == 16'd0) begin
            chk("zero_cnt_done", {core_rst, done, busy, error}, 32'b1100);
        end else if (int'(cnt) > DEPTH) begin
            chk("oversize_status", {core_rst, done, error, rx_ready}, 32'b0010);
        end else begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = words_q[i];
                for (int k = 0; k < 4; k++) begin
                    idle($urandom_range(gap_max, 0));
                    send_byte(w[8*k +: 8], ok);
                    if (!ok) return;
                end
                exp_q.push_back('{addr: ADDR_W'(i), data: w});
            end
            chk("write_cycle_core_held", {core_rst, done}, 32'b00);
            idle(1);
            chk("load_done_status", {core_rst, done, busy, error}, 32'b1100);
            chk("writes_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic do_restart(input bit with_valid);
        restart  = 1'b1;
        rx_valid = with_valid;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        chk("restart_status", {done, error, core_rst, rx_ready, busy}, 32'b00010);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c;
        bit err_early;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {imem_we, core_rst, busy, done, error, rx_ready}, 32'b000001);
        chk("reset_addr_data", {28'(imem_addr), imem_wdata}, 60'd0);
        rst = 1'b1;
        idle(1);

        // Single known instruction.
        words_q.delete();
        words_q.push_back(32'h00A00513);
        run_load(16'd1, 0);
        do_restart(1'b1);

        // Three words back-to-back.
        rand_words(3);
        run_load(16'd3, 0);
        do_restart(1'b0);

        // Empty program.
        run_load(16'd0, 0);
        do_restart(1'b0);

        // One word more than memory holds.
        run_load(16'd17, 0);
        do_restart(1'b0);

        // Exactly full memory.
        rand_words(DEPTH);
        run_load(16'(DEPTH), 2);
        do_restart(1'b1);

        // Inter-byte timeout after two data bytes.
        send_byte(8'h01, ok);
        send_byte(8'h00, ok);
        send_byte(8'h11, ok);
        send_byte(8'h22, ok);
        err_early = 1'b0;
        for (int i = 0; i < TO_CYC; i++) begin
            if (error) err_early = 1'b1;
            idle(1);
        end
        chk("timeout_not_early", 32'(err_early), 32'd0);
        chk("timeout_status", {error, rx_ready, core_rst, busy}, 32'b1000);
        do_restart(1'b0);

        // Asynchronous reset in the middle of the second word.
        rand_words(2);
        send_byte(8'h02, ok);
        send_byte(8'h00, ok);
        for (int k = 0; k < 4; k++) send_byte(words_q[0][8*k +: 8], ok);
        exp_q.push_back('{addr: '0, data: words_q[0]});
        send_byte(8'hDE, ok);
        send_byte(8'hAD, ok);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {imem_we, core_rst, busy, done, error}, 32'b00000);
        chk("async_reset_addr_data", {28'(imem_addr), imem_wdata}, 60'd0);
        exp_q.delete();
        idle(2);
        rst = 1'b1;
        idle(1);
        rand_words(1);
        run_load(16'd1, 1);
        do_restart(1'b0);

        // Randomized loads.
        for (int t = 0; t < 12; t++) begin
            c = $urandom_range(9, 0);
            if (c == 0)      c = 0;
            else if (c == 1) c = $urandom_range(300, DEPTH + 1);
            else             c = $urandom_range(DEPTH, 1);
            rand_words(c);
            run_load(16'(c), $urandom_range(4, 0));
            do_restart(1'($urandom));
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
